// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM handshake state, memory arbiter grant state.
// Imported by the memory arbiter and its starvation counter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts data grants taken while a fetch waits; raises force_i at the limit.
// Ports: clk, rst, idle, ireq, dgo, igo in; force_i, count out.
module arb_starve_ctr
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          idle,
  input  logic          ireq,
  input  logic          dgo,
  input  logic          igo,
  output logic          force_i,
  output logic [CW-1:0] count
);

  assign force_i = (count == CW'(STARVE_LIMIT));

  // Only IDLE decisions move the counter; it saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (idle) begin
      if (!ireq || igo) begin
        count <= '0;
      end else if (dgo && !force_i) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access, data first.
// Ports: CLK, RST, i*/d* requester sides, ram* RAM side.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate
);

  arb_state_t state, nxt;
  logic dreq, dgo, igo, force_i;

  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt_unused;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (CLK),
    .rst    (RST),
    .idle   (state == IDLE),
    .ireq   (iREN),
    .dgo    (dgo),
    .igo    (igo),
    .force_i(force_i),
    .count  (starve_cnt_unused)
  );
`else
  logic unused_cfg;
  assign force_i    = 1'b0;
  assign unused_cfg = dgo ^ igo ^ (STARVE_LIMIT > 0);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  // Strobes follow the live request so a dropped request
  // releases the RAM in the same cycle.
  always_comb begin
    nxt      = state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = dreq;
    dgo      = 1'b0;
    igo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (dreq && !(force_i && iREN)) begin
          nxt = DGNT;
          dgo = 1'b1;
        end else if (iREN) begin
          nxt = IGNT;
          igo = 1'b1;
        end
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          nxt = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait = 1'b0;
          nxt   = IDLE;
        end else if (ramstate == ERROR) begin
          nxt = IDLE;
        end
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          nxt = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait = 1'b0;
          nxt   = IDLE;
        end else if (ramstate == ERROR) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared against a port-ownership reference model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIM = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        CLK, RST;
  logic        iREN, iwait, dREN, dWEN, dwait;
  logic        ramREN, ramWEN;
  logic [31:0] iaddr, iload, daddr, dstore, dload;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  int compared = 0;
  int mismatched = 0;

  // Model: who owns the RAM port (0 none, 1 fetch, 2 data)
  // and how many data grants were taken while a fetch waited.
  int owner = 0;
  int starve = 0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string t);
    logic dq, acc, e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    dq  = dREN | dWEN;
    acc = (ramstate == ACCESS);
    e_ren   = (owner == 1) ? iREN : (owner == 2) ? (dREN & ~dWEN) : 1'b0;
    e_wen   = (owner == 2) ? dWEN : 1'b0;
    e_addr  = (owner == 1) ? iaddr : (owner == 2) ? daddr : 32'h0;
    e_store = (owner == 2) ? dstore : 32'h0;
    chk({t, ".ren"}, ramREN, e_ren);
    chk({t, ".wen"}, ramWEN, e_wen);
    chk({t, ".addr"}, ramaddr, e_addr);
    chk({t, ".store"}, ramstore, e_store);
    chk({t, ".iwait"}, iwait, iREN & ~(owner == 1 && acc));
    chk({t, ".dwait"}, dwait, dq & ~(owner == 2 && acc));
    chk({t, ".iload"}, iload, ramload);
    chk({t, ".dload"}, dload, ramload);
  endtask

  function automatic void model_step();
    logic dq, held;
    dq = dREN | dWEN;
    if (owner == 0) begin
      if (dq && !(GUARD && iREN && starve >= LIM)) begin
        owner  = 2;
        starve = iREN ? ((starve < LIM) ? starve + 1 : LIM) : 0;
      end else if (iREN) begin
        owner  = 1;
        starve = 0;
      end else begin
        starve = 0;
      end
    end else begin
      held = (owner == 1) ? iREN : dq;
      if (!held || ramstate == ACCESS || ramstate == ERROR) owner = 0;
    end
  endfunction

  task automatic settle(input string t);
    #1;
    check_all(t);
  endtask

  task automatic adv();
    model_step();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    ramstate = FREE;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    owner = 0;
    starve = 0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  string order, exp_order;

  initial begin
    RST = 1'b1;
    idle_inputs();
    iREN = 1'b1;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 32'h1234;
    settle("rst");
    chk("rst_ren", ramREN, 0);
    chk("rst_iwait", iwait, 1);
    @(negedge CLK);
    RST = 1'b0;
    idle_inputs();
    settle("rst_rel");
    adv();

    // 1: fetch, ACCESS on the second strobe cycle
    iREN = 1; iaddr = 32'h100;
    settle("t1c0"); chk("t1c0_ren", ramREN, 0); adv();
    ramstate = BUSY;
    settle("t1c1"); chk("t1c1_ren", ramREN, 1);
    chk("t1c1_addr", ramaddr, 32'h100); adv();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    settle("t1c2"); chk("t1c2_iwait", iwait, 0);
    chk("t1c2_iload", iload, 32'hDEADBEEF); adv();
    iREN = 0; ramstate = FREE;
    settle("t1c3"); chk("t1c3_ren", ramREN, 0); adv();

    // 2: simultaneous fetch and write, write first
    iREN = 1; iaddr = 32'h104;
    dWEN = 1; daddr = 32'h200; dstore = 32'h5A5A5A5A;
    settle("t2c0"); adv();
    ramstate = ACCESS;
    settle("t2c1"); chk("t2c1_wen", ramWEN, 1);
    chk("t2c1_addr", ramaddr, 32'h200);
    chk("t2c1_iwait", iwait, 1); adv();
    dWEN = 0; ramstate = FREE;
    settle("t2c2"); chk("t2c2_ren", ramREN, 0);
    chk("t2c2_iwait", iwait, 1); adv();
    settle("t2c3"); chk("t2c3_ren", ramREN, 1);
    chk("t2c3_addr", ramaddr, 32'h104);
    chk("t2c3_iwait", iwait, 1); adv();
    ramstate = ACCESS;
    settle("t2c4"); adv();
    idle_inputs(); settle("t2c5"); adv();

    // 3: data read, ERROR then retry to ACCESS
    dREN = 1; daddr = 32'h300;
    settle("t3c0"); adv();
    ramstate = ERROR;
    settle("t3c1"); chk("t3c1_ren", ramREN, 1);
    chk("t3c1_dwait", dwait, 1); adv();
    ramstate = FREE;
    settle("t3c2"); chk("t3c2_ren", ramREN, 0);
    chk("t3c2_dwait", dwait, 1); adv();
    ramstate = ACCESS;
    settle("t3c3"); chk("t3c3_ren", ramREN, 1);
    chk("t3c3_dwait", dwait, 0); adv();
    idle_inputs(); settle("t3c4"); adv();

    // 4: data read dropped while BUSY
    dREN = 1; daddr = 32'h400;
    settle("t4c0"); adv();
    ramstate = BUSY;
    settle("t4c1"); chk("t4c1_ren", ramREN, 1); adv();
    dREN = 0;
    settle("t4c2"); chk("t4c2_ren", ramREN, 0); adv();
    dREN = 1;
    settle("t4c3"); chk("t4c3_ren", ramREN, 0);
    chk("t4c3_dwait", dwait, 1); adv();
    ramstate = ACCESS;
    settle("t4c4"); chk("t4c4_ren", ramREN, 1); adv();
    idle_inputs(); settle("t4c5"); adv();

    // 5: reset during a fetch grant
    iREN = 1; iaddr = 32'h500;
    settle("t5c0"); adv();
    ramstate = BUSY;
    settle("t5c1"); chk("t5c1_ren", ramREN, 1);
    RST = 1'b1;
    owner = 0; starve = 0;
    #1;
    chk("t5_rst_ren", ramREN, 0);
    chk("t5_rst_iwait", iwait, 1);
    @(negedge CLK);
    RST = 1'b0;
    settle("t5c2"); chk("t5c2_ren", ramREN, 0);
    chk("t5c2_iwait", iwait, 1); adv();
    ramstate = ACCESS;
    settle("t5c3"); chk("t5c3_iwait", iwait, 0); adv();
    idle_inputs(); settle("t5c4"); adv();

    // 6: continuous fetch and data reads, grant order
    do_reset();
    iREN = 1; iaddr = 32'h600;
    dREN = 1; daddr = 32'h700; ramstate = ACCESS;
    order = "";
    for (int c = 0; c < 12; c++) begin
      settle("t6");
      if (ramREN) order = {order, (ramaddr == 32'h700) ? "D" : "I"};
      adv();
    end
    exp_order = "";
    for (int k = 0; k < 6; k++)
      exp_order = {exp_order,
                   (GUARD && (k % (LIM + 1)) == LIM) ? "I" : "D"};
    compared++;
    assert (order == exp_order) else begin
      mismatched++;
      $error("FAIL t6_order: observed %s expected %s", order, exp_order);
    end
    idle_inputs(); settle("t6_end"); adv();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      iREN     = ($urandom_range(0, 3) != 0);
      dREN     = ($urandom_range(0, 2) == 0);
      dWEN     = ($urandom_range(0, 3) == 0);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      settle("rnd");
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
